rvm_trap_ctrl: RTL and testbench
================================

Name: rvm_trap_ctrl

Overview:
- Parametrised machine-mode trap and interrupt controller for the multi-cycle core. It supports NUM_IRQ external interrupt lines.
- Edge-detects and latches pending interrupts, masks them with per-line enables and mstatus.MIE, and arbitrates exceptions against interrupts.
- Sequences trap entry and mret through a small FSM, owning mstatus/mie/mip/mtvec/mepc/mcause/mtval.
- Sits beside the system control unit and drives the PCU redirect.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines, legal 1..16.
- MTVEC_RESET, 32'h0000_01C0, reset value of mtvec.

Ports:
- clk  input  1  core clock
- resetn  input  1  asynchronous active-low reset
- core_stall  input  1  core stalled; no new trap/mret accepted
- pc  input  32  PC of current instruction
- instr_retired  input  1  instruction boundary; interrupts taken only here
- exc_valid  input  1  synchronous exception this cycle
- exc_cause  input  4  exception code
- exc_tval  input  32  faulting address/instruction
- mret  input  1  mret executing
- irq_in  input  NUM_IRQ  level interrupt lines, already synchronised
- csr_wen  input  1  CSR write strobe
- csr_addr  input  12  CSR address (read and write)
- csr_wdata  input  32  CSR write data
- csr_rdata  output  32  CSR read data, combinational from csr_addr
- redirect  output  1  PCU must load redirect_pc
- redirect_pc  output  32  trap target or mepc
- mepc  output  32  current mepc

Behaviour:
- Reset values (all asynchronous):
  - FSM = IDLE; redirect = 0; redirect_pc = 0.
  - mstatus.MIE/MPIE = 0; mie = 0; pending = 0.
  - mtvec = MTVEC_RESET; mepc/mcause/mtval = 0.
  - Edge-detect history = 0.
- Pending logic:
  - Bit i sets on a rising edge of irq_in[i], i.e. irq_in[i] & ~irq_q[i].
  - Bit i clears when interrupt i is taken, or on a mip write with wdata[16+i]=0. Writing 1 has no effect.
  - A set and a clear in the same cycle: set wins.
- CSR map:
  - mstatus 0x300: MIE bit3, MPIE bit7, other bits read 0.
  - mie 0x304: enables at bits [16+NUM_IRQ-1:16].
  - mtvec 0x305.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342.
  - mtval 0x343.
  - mip 0x344: pending at bits [16+NUM_IRQ-1:16].
  - Unmapped addresses read 0 and ignore writes.
- Arbitration, IDLE state, only when !core_stall:
  - Priority: exc_valid > enabled interrupt > mret.
  - An interrupt is eligible when MIE & |(pending & mie) & instr_retired.
  - Among eligible interrupts, the lowest index wins.
- FSM: IDLE -> ENTER -> IDLE, and IDLE -> RETURN -> IDLE. Each non-IDLE state lasts exactly one cycle.
- Clock edge accepting a trap:
  - mepc <= {pc[31:2],2'b00}.
  - mcause <= {0,28'b0,exc_cause} for an exception; {1,26'b0,16+i} for interrupt i.
  - mtval <= exc_tval for an exception, else 0.
  - MPIE <= MIE; MIE <= 0; pending[i] cleared.
- In ENTER: redirect=1 and redirect_pc = {mtvec[31:2],2'b00}.
- Clock edge accepting mret: MIE <= MPIE; MPIE <= 1.
- In RETURN: redirect=1 and redirect_pc = mepc.
- Latency: redirect is asserted exactly one cycle after the accepting cycle.
- Events arriving in ENTER/RETURN are ignored, except irq edges, which still latch into pending.
- A CSR write in the same cycle as trap/mret acceptance is dropped for mstatus/mepc/mcause/mtval/mip. Writes to mie/mtvec proceed.
- mtvec writes store bits[31:2]; bits[1:0] read 00.
- Asynchronous reset mid-ENTER/RETURN returns the FSM to IDLE with redirect=0 immediately.

Optional Feature:
- Macro: RVM_TRAP_VECTORED_EN.
- Defined:
  - mtvec[1:0] writable, holding only the values 00 or 01.
  - With mode 01, interrupt targets are base + 4*(16+i); exceptions use base.
  - Writes of 10/11 leave the mode unchanged.
- Undefined: mtvec[1:0] hardwired 00 and all traps target base.

Decomposition:
- rvm_constants.v gains:
  - CSR addresses 0x300/0x304/0x305/0x341-0x344.
  - RVM_TRAP_IRQ_BASE = 16.
  - FSM state encodings IDLE/ENTER/RETURN.
  - Bit positions of mstatus.MIE and MPIE.
- One sub-module, rvm_irq_pending, parametrised by NUM_IRQ. It contains:
  - edge-detect registers;
  - pending register with set/clear;
  - mask;
  - lowest-index priority encoder producing irq_any and irq_id[3:0].

Test Plan:
- Reset with MTVEC_RESET default -> csr_rdata: mtvec=0x1C0, mstatus=0, mip=0; redirect=0.
- mstatus=0x8, mie=0x0003_0000; pulse irq_in[1] then irq_in[0] together with instr_retired=1, pc=0x104 -> redirect 1 cycle later to 0x1C0; mcause=0x8000_0010; mepc=0x104; MIE=0, MPIE=1; pending bit0 cleared, bit1 still set.
- exc_valid=1, exc_cause=2, exc_tval=0xDEAD_BEEF with an enabled pending irq in the same cycle -> exception wins: mcause=2, mtval=0xDEADBEEF; irq remains pending.
- mret with MPIE=1, MIE=0, mepc=0x200 -> redirect_pc=0x200 one cycle later; MIE=1, MPIE=1. The pending irq is then taken on the next instr_retired.
- core_stall=1 with exc_valid=1 -> no redirect. csr_wen to mepc (0x341) in the same cycle that a trap is accepted -> mepc holds the trap pc, not the write data.
- With RVM_TRAP_VECTORED_EN: mtvec=0x1001, irq1 taken -> redirect_pc=0x1044. Without the macro: mtvec reads 0x1000 and redirect_pc=0x1000.

Source files
------------

// File: rtl/rvm_trap_ctrl_pkg.sv
// rtl/rvm_trap_ctrl_pkg.sv - shared constants and state type for the machine-mode trap controller
// Contents: CSR addresses, interrupt cause base, mstatus bit positions, FSM state encoding.
package rvm_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // External interrupt i is reported as cause 16+i and lives at bit 16+i of mie/mip.
    localparam int RVM_TRAP_IRQ_BASE = 16;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTER  = 2'd1,
        ST_RETURN = 2'd2
    } trap_state_e;

endpackage

// File: rtl/rvm_irq_pending.sv
// rtl/rvm_irq_pending.sv - interrupt edge detect, pending latch, masking and lowest-index priority encoder
// Ports: clk/resetn (async active-low), irq_in level lines, irq_en per-line enables, glob_en (mstatus.MIE),
//        mip_wen/mip_wdata software clear, take (selected irq accepted), pending, irq_any, irq_id.
module rvm_irq_pending #(
    parameter int NUM_IRQ = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               glob_en,
    input  logic               mip_wen,
    input  logic [NUM_IRQ-1:0] mip_wdata,
    input  logic               take,
    output logic [NUM_IRQ-1:0] pending,
    output logic               irq_any,
    output logic [3:0]         irq_id
);

    logic [NUM_IRQ-1:0] irq_q, irq_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] masked;

    always_comb begin
        irq_d   = irq_in;
        masked  = pending_q & irq_en & {NUM_IRQ{glob_en}};
        irq_any = |masked;
        // Scan downwards so the lowest set index is the last one written.
        irq_id  = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (masked[i]) begin
                irq_id = 4'(i);
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        // Software can only clear pending bits; writing 1 keeps the current value.
        if (mip_wen) begin
            pending_d = pending_d & mip_wdata;
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (take && irq_id == 4'(i)) begin
                pending_d[i] = 1'b0;
            end
        end
        // A fresh edge overrides any clear in the same cycle.
        pending_d = pending_d | (irq_in & ~irq_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_q     <= '0;
            pending_q <= '0;
        end else begin
            irq_q     <= irq_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/rvm_trap_ctrl.sv
// rtl/rvm_trap_ctrl.sv - machine-mode trap/interrupt controller: CSRs, exception/irq/mret arbitration, PCU redirect
// Ports: clk, resetn (async active-low), core_stall, pc, instr_retired, exc_valid/exc_cause/exc_tval, mret,
//        irq_in[NUM_IRQ], csr_wen/csr_addr/csr_wdata/csr_rdata, redirect/redirect_pc, mepc.
// Option: RVM_TRAP_VECTORED_EN enables mtvec mode 01 (vectored interrupt targets).
import rvm_trap_ctrl_pkg::*;

module rvm_trap_ctrl #(
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_01C0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               core_stall,
    input  logic [31:0]        pc,
    input  logic               instr_retired,
    input  logic               exc_valid,
    input  logic [3:0]         exc_cause,
    input  logic [31:0]        exc_tval,
    input  logic               mret,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               csr_wen,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic [31:0]        mepc
);

    localparam logic [4:0] IRQ_BASE5 = 5'(RVM_TRAP_IRQ_BASE);

    trap_state_e        state_q, state_d;
    logic               st_mie_q, st_mie_d;
    logic               st_mpie_q, st_mpie_d;
    logic [NUM_IRQ-1:0] mie_q, mie_d;
    logic [29:0]        mtvec_base_q, mtvec_base_d;
    logic               mtvec_mode_q, mtvec_mode_d;
    logic [31:0]        mepc_q, mepc_d;
    logic [31:0]        mcause_q, mcause_d;
    logic [31:0]        mtval_q, mtval_d;

    logic [NUM_IRQ-1:0] pending;
    logic               irq_any;
    logic [3:0]         irq_id;
    logic               take_exc, take_irq, take_mret, accept;
    logic               mip_wen;
    logic               unused_pc_bits;

    assign unused_pc_bits = ^pc[1:0];

    // Arbitration: exception > eligible interrupt > mret, only from IDLE and when not stalled.
    always_comb begin
        take_exc  = (state_q == ST_IDLE) && !core_stall && exc_valid;
        take_irq  = (state_q == ST_IDLE) && !core_stall && !exc_valid && irq_any && instr_retired;
        take_mret = (state_q == ST_IDLE) && !core_stall && !exc_valid
                    && !(irq_any && instr_retired) && mret;
        accept    = take_exc || take_irq || take_mret;
        mip_wen   = csr_wen && (csr_addr == CSR_MIP) && !accept;
    end

    rvm_irq_pending #(.NUM_IRQ(NUM_IRQ)) u_pending (
        .clk       (clk),
        .resetn    (resetn),
        .irq_in    (irq_in),
        .irq_en    (mie_q),
        .glob_en   (st_mie_q),
        .mip_wen   (mip_wen),
        .mip_wdata (csr_wdata[RVM_TRAP_IRQ_BASE +: NUM_IRQ]),
        .take      (take_irq),
        .pending   (pending),
        .irq_any   (irq_any),
        .irq_id    (irq_id)
    );

    always_comb begin
        state_d      = state_q;
        st_mie_d     = st_mie_q;
        st_mpie_d    = st_mpie_q;
        mie_d        = mie_q;
        mtvec_base_d = mtvec_base_q;
        mtvec_mode_d = mtvec_mode_q;
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        mtval_d      = mtval_q;

        // Registers that trap/mret also update lose a coinciding software write.
        if (csr_wen && !accept) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    st_mie_d  = csr_wdata[MSTATUS_MIE_BIT];
                    st_mpie_d = csr_wdata[MSTATUS_MPIE_BIT];
                end
                CSR_MEPC:   mepc_d   = {csr_wdata[31:2], 2'b00};
                CSR_MCAUSE: mcause_d = csr_wdata;
                CSR_MTVAL:  mtval_d  = csr_wdata;
                default: ;
            endcase
        end
        if (csr_wen) begin
            case (csr_addr)
                CSR_MIE: mie_d = csr_wdata[RVM_TRAP_IRQ_BASE +: NUM_IRQ];
                CSR_MTVEC: begin
                    mtvec_base_d = csr_wdata[31:2];
`ifdef RVM_TRAP_VECTORED_EN
                    // Only modes 00 and 01 exist; 10/11 leave the mode alone.
                    if (!csr_wdata[1]) begin
                        mtvec_mode_d = csr_wdata[0];
                    end
`else
                    mtvec_mode_d = 1'b0;
`endif
                end
                default: ;
            endcase
        end

        if (take_exc || take_irq) begin
            mepc_d    = {pc[31:2], 2'b00};
            mcause_d  = take_exc ? {28'b0, exc_cause}
                                 : {1'b1, 26'b0, IRQ_BASE5 + {1'b0, irq_id}};
            mtval_d   = take_exc ? exc_tval : 32'b0;
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
        end
        if (take_mret) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (take_exc || take_irq) begin
                    state_d = ST_ENTER;
                end else if (take_mret) begin
                    state_d = ST_RETURN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Redirect is a pure decode of state, so reset drops it immediately.
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = 32'b0;
        case (state_q)
            ST_ENTER: begin
                redirect    = 1'b1;
                redirect_pc = {mtvec_base_q, 2'b00};
                if (mtvec_mode_q && mcause_q[31]) begin
                    redirect_pc = redirect_pc + {25'b0, mcause_q[4:0], 2'b00};
                end
            end
            ST_RETURN: begin
                redirect    = 1'b1;
                redirect_pc = mepc_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        csr_rdata = 32'b0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[MSTATUS_MIE_BIT]  = st_mie_q;
                csr_rdata[MSTATUS_MPIE_BIT] = st_mpie_q;
            end
            CSR_MIE:    csr_rdata[RVM_TRAP_IRQ_BASE +: NUM_IRQ] = mie_q;
            CSR_MTVEC:  csr_rdata = {mtvec_base_q, 1'b0, mtvec_mode_q};
            CSR_MEPC:   csr_rdata = mepc_q;
            CSR_MCAUSE: csr_rdata = mcause_q;
            CSR_MTVAL:  csr_rdata = mtval_q;
            CSR_MIP:    csr_rdata[RVM_TRAP_IRQ_BASE +: NUM_IRQ] = pending;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            st_mie_q     <= 1'b0;
            st_mpie_q    <= 1'b0;
            mie_q        <= '0;
            mtvec_base_q <= MTVEC_RESET[31:2];
`ifdef RVM_TRAP_VECTORED_EN
            mtvec_mode_q <= (MTVEC_RESET[1:0] == 2'b01);
`else
            mtvec_mode_q <= 1'b0;
`endif
            mepc_q       <= 32'b0;
            mcause_q     <= 32'b0;
            mtval_q      <= 32'b0;
        end else begin
            state_q      <= state_d;
            st_mie_q     <= st_mie_d;
            st_mpie_q    <= st_mpie_d;
            mie_q        <= mie_d;
            mtvec_base_q <= mtvec_base_d;
            mtvec_mode_q <= mtvec_mode_d;
            mepc_q       <= mepc_d;
            mcause_q     <= mcause_d;
            mtval_q      <= mtval_d;
        end
    end

    assign mepc = mepc_q;

endmodule

// File: tb/tb_rvm_trap_ctrl.sv
// tb/tb_rvm_trap_ctrl.sv - directed self-checking bench for rvm_trap_ctrl
module tb_rvm_trap_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        core_stall;
    logic [31:0] pc;
    logic        instr_retired;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_tval;
    logic        mret;
    logic [3:0]  irq_in;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] mepc;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    rvm_trap_ctrl #(.NUM_IRQ(4), .MTVEC_RESET(32'h0000_01C0)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .core_stall    (core_stall),
        .pc            (pc),
        .instr_retired (instr_retired),
        .exc_valid     (exc_valid),
        .exc_cause     (exc_cause),
        .exc_tval      (exc_tval),
        .mret          (mret),
        .irq_in        (irq_in),
        .csr_wen       (csr_wen),
        .csr_addr      (csr_addr),
        .csr_wdata     (csr_wdata),
        .csr_rdata     (csr_rdata),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .mepc          (mepc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_addr = addr;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        csr_wen   = 1'b1;
        csr_addr  = addr;
        csr_wdata = data;
        tick();
        csr_wen   = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; core_stall = 1'b0; pc = 32'h0; instr_retired = 1'b0;
        exc_valid = 1'b0; exc_cause = 4'h0; exc_tval = 32'h0; mret = 1'b0;
        irq_in = 4'b0; csr_wen = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0;
        tick(); tick();
        resetn = 1'b1;

        // Reset state
        check("rst_redirect", {31'b0, redirect}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        rd("rst_mtvec", 12'h305, 32'h0000_01C0);
        rd("rst_mstatus", 12'h300, 32'h0);
        rd("rst_mip", 12'h344, 32'h0);

        // Configure MIE and enables for irq0/irq1
        wr(12'h300, 32'h8);
        wr(12'h304, 32'h0003_0000);
        rd("cfg_mstatus", 12'h300, 32'h8);
        rd("cfg_mie", 12'h304, 32'h0003_0000);

        // irq1 edge, then irq0 edge; lowest index taken at retirement
        irq_in = 4'b0010; tick();
        irq_in = 4'b0001; tick();
        rd("pend_both", 12'h344, 32'h0003_0000);
        instr_retired = 1'b1; pc = 32'h0000_0104;
        check("irq_pre_redirect", {31'b0, redirect}, 32'd0);
        tick();
        instr_retired = 1'b0;
        check("irq0_redirect", {31'b0, redirect}, 32'd1);
        check("irq0_target", redirect_pc, 32'h0000_01C0);
        rd("irq0_mcause", 12'h342, 32'h8000_0010);
        rd("irq0_mepc", 12'h341, 32'h0000_0104);
        rd("irq0_mstatus", 12'h300, 32'h80);
        rd("irq0_mip", 12'h344, 32'h0002_0000);
        tick();
        check("irq0_redirect_drop", {31'b0, redirect}, 32'd0);

        // Exception beats an enabled pending irq
        wr(12'h300, 32'h88);
        exc_valid = 1'b1; exc_cause = 4'd2; exc_tval = 32'hDEAD_BEEF;
        instr_retired = 1'b1; pc = 32'h0000_0200;
        tick();
        exc_valid = 1'b0; instr_retired = 1'b0;
        check("exc_redirect", {31'b0, redirect}, 32'd1);
        rd("exc_mcause", 12'h342, 32'h0000_0002);
        rd("exc_mtval", 12'h343, 32'hDEAD_BEEF);
        rd("exc_mip", 12'h344, 32'h0002_0000);
        rd("exc_mstatus", 12'h300, 32'h80);
        check("exc_mepc_port", mepc, 32'h0000_0200);
        tick();

        // mret returns to mepc and restores MIE
        mret = 1'b1;
        tick();
        mret = 1'b0;
        check("mret_redirect", {31'b0, redirect}, 32'd1);
        check("mret_target", redirect_pc, 32'h0000_0200);
        rd("mret_mstatus", 12'h300, 32'h88);
        tick();
        check("mret_no_irq_wo_retire", {31'b0, redirect}, 32'd0);

        // Pending irq1 taken on next retirement
        instr_retired = 1'b1; pc = 32'h0000_0300;
        tick();
        instr_retired = 1'b0;
        check("irq1_redirect", {31'b0, redirect}, 32'd1);
        rd("irq1_mcause", 12'h342, 32'h8000_0011);
        rd("irq1_mip", 12'h344, 32'h0);
        // Events during ENTER: exception ignored, irq2 edge latched
        exc_valid = 1'b1; exc_cause = 4'd5; irq_in = 4'b0100;
        tick();
        exc_valid = 1'b0;
        check("enter_exc_ignored", {31'b0, redirect}, 32'd0);
        rd("enter_mcause_kept", 12'h342, 32'h8000_0011);
        rd("enter_irq_latched", 12'h344, 32'h0004_0000);

        // Stall blocks exception acceptance
        core_stall = 1'b1; exc_valid = 1'b1; exc_cause = 4'd7;
        tick();
        check("stall_no_redirect1", {31'b0, redirect}, 32'd0);
        tick();
        check("stall_no_redirect2", {31'b0, redirect}, 32'd0);
        core_stall = 1'b0; exc_valid = 1'b0;
        rd("stall_mcause_kept", 12'h342, 32'h8000_0011);

        // mepc write coinciding with trap acceptance is dropped
        exc_valid = 1'b1; exc_cause = 4'd3; exc_tval = 32'h0; pc = 32'h0000_0400;
        csr_wen = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h1234_5678;
        tick();
        csr_wen = 1'b0; exc_valid = 1'b0;
        check("coll_mepc_port", mepc, 32'h0000_0400);
        rd("coll_mcause", 12'h342, 32'h0000_0003);
        rd("coll_mtval", 12'h343, 32'h0);
        tick();

        // Plain mepc write aligns; unmapped address reads zero
        wr(12'h341, 32'h0000_0123);
        rd("mepc_align", 12'h341, 32'h0000_0120);
        wr(12'h345, 32'hFFFF_FFFF);
        rd("unmapped", 12'h345, 32'h0);

        // mip: writing 1 keeps, writing 0 clears, new edge beats clear
        wr(12'h344, 32'hFFFF_FFFF);
        rd("mip_w1_keep", 12'h344, 32'h0004_0000);
        irq_in = 4'b1100;
        wr(12'h344, 32'h0);
        rd("mip_set_wins", 12'h344, 32'h0008_0000);

        // mtvec base write and irq1 target
        wr(12'h300, 32'h8);
        wr(12'h305, 32'h0000_1001);
`ifdef RVM_TRAP_VECTORED_EN
        rd("mtvec_rd", 12'h305, 32'h0000_1001);
`else
        rd("mtvec_rd", 12'h305, 32'h0000_1000);
`endif
        irq_in = 4'b1110;
        tick();
        instr_retired = 1'b1; pc = 32'h0000_0500;
        tick();
        instr_retired = 1'b0;
        check("vec_redirect", {31'b0, redirect}, 32'd1);
`ifdef RVM_TRAP_VECTORED_EN
        check("vec_target", redirect_pc, 32'h0000_1044);
`else
        check("vec_target", redirect_pc, 32'h0000_1000);
`endif
        rd("vec_mcause", 12'h342, 32'h8000_0011);

        // Async reset in ENTER drops redirect immediately
        resetn = 1'b0;
        #1;
        check("areset_redirect", {31'b0, redirect}, 32'd0);
        check("areset_redirect_pc", redirect_pc, 32'h0);
        rd("areset_mtvec", 12'h305, 32'h0000_01C0);
        rd("areset_mip", 12'h344, 32'h0);
        tick();
        resetn = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
